// File: rtl/prog_mem.sv
// Loadable program memory: the CPU fetches combinationally while in RUN, and a
// valid/ready loader rewrites the whole memory while in LOAD with the CPU held.
module prog_mem #(
   parameter int unsigned OP_W   = 4,
   parameter int unsigned IMM_W  = 4,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_W-1:0]       fetch_addr,
   output logic [OP_W-1:0]         opcode_out,
   output logic [IMM_W-1:0]        imm_out,
   input  logic                    load_start,
   input  logic                    load_abort,
   input  logic                    load_valid,
   input  logic [OP_W+IMM_W-1:0]   load_data,
   output logic                    load_ready,
   output logic [ADDR_W-1:0]       load_ptr,
   output logic                    cpu_hold,
   output logic                    load_done
);

   localparam int unsigned WORD_W = OP_W + IMM_W;
   localparam int unsigned DEPTH  = 32'(1) << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   ptr_nxt;
   logic                done_nxt;
   logic                wr_en;
   logic [WORD_W-1:0]   mem [DEPTH];
   logic [WORD_W-1:0]   rd_word;

   // State, pointer and done-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         load_ptr  <= '0;
         load_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         load_ptr  <= ptr_nxt;
         load_done <= done_nxt;
      end
   end

   // Next-state logic; abort outranks both start and a pending transfer
   always_comb begin
      state_nxt = state;
      ptr_nxt   = load_ptr;
      done_nxt  = 1'b0;
      wr_en     = 1'b0;
      case (state)
         RUN: begin
            if (load_start && !load_abort) begin
               state_nxt = LOAD;
               ptr_nxt   = '0;
            end
         end
         LOAD: begin
            if (load_abort) begin
               state_nxt = RUN;
               ptr_nxt   = '0;
            end else if (load_valid) begin
               wr_en = 1'b1;
               if (load_ptr == LAST_ADDR) begin
                  state_nxt = RUN;
                  ptr_nxt   = '0;
                  done_nxt  = 1'b1;
               end else begin
                  ptr_nxt = load_ptr + ADDR_W'(1);
               end
            end
         end
      endcase
   end

   // Handshake status and fetch port; fetch returns a NOP while loading
   always_comb begin
      load_ready = 1'b0;
      cpu_hold   = 1'b0;
      opcode_out = '0;
      imm_out    = '0;
      rd_word    = mem[fetch_addr];
      if (state == LOAD) begin
         load_ready = 1'b1;
         cpu_hold   = 1'b1;
      end else begin
         opcode_out = rd_word[OP_W-1:0];
         imm_out    = rd_word[WORD_W-1:OP_W];
      end
   end

   // Storage words, each cleared by reset and written only at load_ptr
   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mem[g] <= '0;
         end else if (wr_en && (load_ptr == ADDR_W'(g))) begin
            mem[g] <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: a reference model of the load protocol is
// compared against the DUT every cycle, alongside hand-computed fetch results.
module tb_prog_mem;

   logic       clk;
   logic       rst_n;
   logic [3:0] fetch_addr;
   logic [3:0] opcode_out;
   logic [3:0] imm_out;
   logic       load_start;
   logic       load_abort;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic [3:0] load_ptr;
   logic       cpu_hold;
   logic       load_done;

   int n_chk    = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int hold_cnt = 0;
   bit chk_en   = 0;

   // Reference model state
   logic [7:0] m_mem [16];
   bit         m_load;
   int         m_ptr;
   bit         m_done;
   logic [7:0] exp_word;

   prog_mem #(.OP_W(4), .IMM_W(4), .ADDR_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_addr (fetch_addr),
      .opcode_out (opcode_out),
      .imm_out    (imm_out),
      .load_start (load_start),
      .load_abort (load_abort),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_ptr   (load_ptr),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: behaviour of the loader as a sequence of whole-cycle events
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
         m_load = 0;
         m_ptr  = 0;
         m_done = 0;
      end else begin
         m_done = 0;
         if (!m_load) begin
            if (load_start && !load_abort) begin
               m_load = 1;
               m_ptr  = 0;
            end
         end else if (load_abort) begin
            m_load = 0;
            m_ptr  = 0;
         end else if (load_valid) begin
            m_mem[m_ptr] = load_data;
            if (m_ptr == 15) begin
               m_load = 0;
               m_ptr  = 0;
               m_done = 1;
            end else begin
               m_ptr = m_ptr + 1;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         exp_word = m_load ? 8'h00 : m_mem[fetch_addr];
         chk("cpu_hold",   32'(cpu_hold),   32'(m_load));
         chk("load_ready", 32'(load_ready), 32'(m_load));
         chk("load_ptr",   32'(load_ptr),   32'(m_ptr));
         chk("load_done",  32'(load_done),  32'(m_done));
         chk("opcode_out", 32'(opcode_out), 32'(exp_word[3:0]));
         chk("imm_out",    32'(imm_out),    32'(exp_word[7:4]));
         if (load_done) done_cnt++;
         if (cpu_hold)  hold_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [3:0] addr, input logic [3:0] op, input logic [3:0] imm,
                       input string name);
      step();
      fetch_addr = addr;
      #1;
      chk({name, "_op"},  32'(opcode_out), 32'(op));
      chk({name, "_imm"}, 32'(imm_out),    32'(imm));
   endtask

   task automatic start_load();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b1;
      fetch_addr = '0;
      load_start = 1'b0;
      load_abort = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      #2 rst_n = 1'b0;
      #1 chk_en = 1;

      // Reset: outputs zero during and after reset, for every address
      peek(4'd7, 4'h0, 4'h0, "in_reset");
      chk("reset_hold", 32'(cpu_hold), 32'(0));
      chk("reset_ready", 32'(load_ready), 32'(0));
      step();
      rst_n = 1'b1;
      for (int a = 0; a < 16; a++) peek(4'(a), 4'h0, 4'h0, "sweep_reset");

      // Full back-to-back load of A0+i
      hold_cnt = 0;
      start_load();
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1;
         load_data  = 8'hA0 + 8'(i);
         step();
      end
      load_valid = 1'b0;
      peek(4'd5, 4'h5, 4'hA, "full_load");
      chk("full_hold_cycles", 32'(hold_cnt), 32'(16));
      chk("full_done_cnt", 32'(done_cnt), 32'(1));

      // Load with a gap after every valid word
      start_load();
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h50 + 8'(i);
         step();
         load_valid = 1'b0;
         load_data  = 8'hEE;
         step();
      end
      peek(4'd3,  4'h3, 4'h5, "gap_load_a");
      peek(4'd12, 4'hC, 4'h5, "gap_load_b");
      chk("gap_done_cnt", 32'(done_cnt), 32'(2));

      // Six words then abort with a valid word present
      start_load();
      for (int i = 0; i < 6; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h3C;
         step();
      end
      load_abort = 1'b1;
      load_data  = 8'hFF;
      step();
      load_abort = 1'b0;
      load_valid = 1'b0;
      chk("abort_hold", 32'(cpu_hold), 32'(0));
      chk("abort_ptr",  32'(load_ptr), 32'(0));
      for (int a = 0; a < 16; a++) begin
         if (a < 6) peek(4'(a), 4'hC, 4'h3, "abort_new");
         else       peek(4'(a), 4'(a), 4'h5, "abort_old");
      end
      chk("abort_done_cnt", 32'(done_cnt), 32'(2));

      // Second start at word 8 must be ignored
      start_load();
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1;
         load_start = (i == 8);
         load_data  = 8'h70 + 8'(i);
         step();
      end
      load_valid = 1'b0;
      load_start = 1'b0;
      peek(4'd9, 4'h9, 4'h7, "restart_a");
      peek(4'd0, 4'h0, 4'h7, "restart_b");
      chk("restart_done_cnt", 32'(done_cnt), 32'(3));

      // Reset dropped at word 10 of a load
      start_load();
      for (int i = 0; i < 10; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h90 + 8'(i);
         step();
      end
      load_data = 8'h9A;
      #2 rst_n = 1'b0;
      step();
      load_valid = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midreset_hold", 32'(cpu_hold), 32'(0));
      chk("midreset_ptr",  32'(load_ptr), 32'(0));
      for (int a = 0; a < 16; a++) peek(4'(a), 4'h0, 4'h0, "midreset_mem");
      chk("midreset_done_cnt", 32'(done_cnt), 32'(3));

      // Abort beats start in RUN; a valid word in RUN writes nothing
      load_abort = 1'b1;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      chk("abort_wins_hold", 32'(cpu_hold), 32'(0));
      step();
      load_abort = 1'b0;
      load_valid = 1'b1;
      load_data  = 8'h55;
      step();
      load_valid = 1'b0;
      peek(4'd0, 4'h0, 4'h0, "run_valid_nowrite");
      chk("run_ptr", 32'(load_ptr), 32'(0));

      step();
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
